// File: rtl/mem_stage.sv
// Load/store memory stage: one request in flight, word-addressed bus, lane steering and load extension.
// Optional bus-ack watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_store,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_wmask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        store_q, unsigned_q, err_q;
    logic [1:0]  size_q;
    logic        accept, bad_req, in_bus, timeout;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata, load_ext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign o_ready = (state == IDLE) & i_rst_n;
    assign accept  = i_valid & o_ready;
    assign in_bus  = (state == BUS);
    assign bad_req = (i_size == 2'd3) | ((i_size == 2'd1) & i_addr[0]) |
                     ((i_size == 2'd2) & (|i_addr[1:0]));

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt;

    // cnt holds the number of non-acked BUS cycles already elapsed
    assign timeout = in_bus & ~i_mem_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          cnt <= '0;
        else if (accept)                       cnt <= '0;
        else if (in_bus & ~i_mem_ack & ~timeout) cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bad_req ? RESP : BUS;
            BUS:     if (i_mem_ack | timeout) state_nxt = RESP;
            RESP:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load extension from the captured bus word
    assign byte_v = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_v = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        case (size_q)
            2'd0:    load_ext = {{24{~unsigned_q & byte_v[7]}}, byte_v};
            2'd1:    load_ext = {{16{~unsigned_q & half_v[15]}}, half_v};
            default: load_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else if (accept) begin
            addr_q     <= i_addr;
            wdata_q    <= i_wdata;
            store_q    <= i_store;
            size_q     <= i_size;
            unsigned_q <= i_unsigned;
            rdata_q    <= '0;
            err_q      <= bad_req;
        end else if (in_bus & i_mem_ack) begin
            rdata_q    <= store_q ? 32'd0 : load_ext;
            err_q      <= 1'b0;
        end else if (timeout) begin
            rdata_q    <= '0;
            err_q      <= 1'b1;
        end
    end

    // Store lane steering; size 3 never reaches BUS
    always_comb begin
        lane_mask  = 4'b0000;
        lane_wdata = 32'd0;
        case (size_q)
            2'd0: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            2'd2: begin
                lane_mask  = 4'b1111;
                lane_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    assign o_mem_req   = in_bus;
    assign o_mem_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
    assign o_mem_we    = in_bus & store_q;
    assign o_mem_wmask = (in_bus & store_q) ? lane_mask : 4'b0000;
    assign o_mem_wdata = (in_bus & store_q) ? lane_wdata : 32'd0;

    assign o_valid = (state == RESP);
    assign o_rdata = o_valid ? rdata_q : 32'd0;
    assign o_err   = o_valid & err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: results expected at push time, compared when o_valid & i_ready.
// Timeout cases run only when MEM_STAGE_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_mem_stage;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_store;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_wmask;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_store(i_store), .i_size(i_size),
        .i_unsigned(i_unsigned), .o_valid(o_valid), .i_ready(i_ready),
        .o_rdata(o_rdata), .o_err(o_err), .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wmask(o_mem_wmask),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every accepted result
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", o_rdata, e.rdata);
                chk("err", {31'd0, o_err}, {31'd0, e.err});
            end
        end
    end

    // One request end to end; caller is at posedge+1 with the stage idle.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic st,
                          input logic [1:0] sz, input logic un, input logic [31:0] bus_rd,
                          input int dly, input int hold);
        exp_t        e;
        logic        bad;
        logic [31:0] sh, ew;
        logic [15:0] h;
        logic [3:0]  em;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        sh  = bus_rd >> (8 * a[1:0]);
        h   = a[1] ? bus_rd[31:16] : bus_rd[15:0];
        case (sz)
            2'd0: begin
                e.rdata = un ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
                em = 4'b0001 << a[1:0];
                ew = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            end
            2'd1: begin
                e.rdata = un ? {16'd0, h} : {{16{h[15]}}, h};
                em = a[1] ? 4'b1100 : 4'b0011;
                ew = {wd[15:0], wd[15:0]};
            end
            default: begin
                e.rdata = bus_rd;
                em = 4'b1111;
                ew = wd;
            end
        endcase
        if (st || bad) e.rdata = 32'd0;
        e.err = bad;
        sb.push_back(e);

        i_ready = (hold == 0);
        i_valid = 1'b1; i_addr = a; i_wdata = wd; i_store = st; i_size = sz; i_unsigned = un;
        @(negedge i_clk);
        chk("ready_idle", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        if (!bad) begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge i_clk);
                chk("mem_req", {31'd0, o_mem_req}, 32'd1);
                chk("mem_addr", o_mem_addr, {a[31:2], 2'b00});
                chk("mem_we", {31'd0, o_mem_we}, {31'd0, st});
                chk("mem_wmask", {28'd0, o_mem_wmask}, st ? {28'd0, em} : 32'd0);
                if (st) chk("mem_wdata", o_mem_wdata, ew);
                if (k == dly) begin
                    i_mem_rdata = bus_rd;
                    i_mem_ack   = 1'b1;
                end
                @(posedge i_clk); #1;
                i_mem_ack = 1'b0;
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            chk("hold_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_rdata", o_rdata, e.rdata);
            chk("hold_ready", {31'd0, o_ready}, 32'd0);
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("resp_valid", {31'd0, o_valid}, 32'd1);
        chk("resp_no_req", {31'd0, o_mem_req}, 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("ready_back", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_store = 1'b0;
        i_size = '0; i_unsigned = 1'b0; i_ready = 1'b1; i_mem_ack = 1'b0; i_mem_rdata = '0;
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_req", {31'd0, o_mem_req}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("ready_after_rst", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;

        // loads: byte/half/word, signed and unsigned lanes
        do_req(32'h0000_0103, 32'd0, 1'b0, 2'd0, 1'b0, 32'h80FF_1234, 2, 0);
        do_req(32'h0000_0103, 32'd0, 1'b0, 2'd0, 1'b1, 32'h80FF_1234, 1, 0);
        do_req(32'h0000_0101, 32'd0, 1'b0, 2'd0, 1'b0, 32'h80FF_1234, 0, 0);
        do_req(32'h0000_0102, 32'd0, 1'b0, 2'd1, 1'b0, 32'h80FF_1234, 0, 0);
        do_req(32'h0000_0100, 32'd0, 1'b0, 2'd1, 1'b1, 32'h80FF_9234, 1, 0);
        do_req(32'h0000_0100, 32'd0, 1'b0, 2'd1, 1'b0, 32'h80FF_9234, 1, 0);
        do_req(32'h0000_0100, 32'd0, 1'b0, 2'd2, 1'b0, 32'h80FF_1234, 0, 0);
        // stores: half upper, byte lane 1, word
        do_req(32'h0000_0202, 32'h0000_ABCD, 1'b1, 2'd1, 1'b0, 32'h5555_5555, 1, 0);
        do_req(32'h0000_0301, 32'h1234_5678, 1'b1, 2'd0, 1'b0, 32'h0, 0, 0);
        do_req(32'h0000_0304, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 32'h0, 2, 0);
        // misaligned / illegal: no bus cycle, error next cycle
        do_req(32'h0000_0101, 32'd0, 1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
        do_req(32'h0000_0100, 32'd0, 1'b0, 2'd3, 1'b0, 32'h0, 0, 0);
        do_req(32'h0000_0103, 32'h1111, 1'b1, 2'd1, 1'b0, 32'h0, 0, 0);
        // backpressure in RESP
        do_req(32'h0000_0102, 32'd0, 1'b0, 2'd1, 1'b1, 32'hCAFE_0000, 1, 5);

        // ack while idle must be ignored
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        chk("idle_ack_no_valid", {31'd0, o_valid}, 32'd0);
        @(posedge i_clk); #1 i_mem_ack = 1'b0;

        // reset mid-BUS abandons the request
        i_valid = 1'b1; i_addr = 32'h0000_0500; i_store = 1'b0; i_size = 2'd2;
        @(posedge i_clk); #1 i_valid = 1'b0;
        @(negedge i_clk);
        chk("pre_rst_req", {31'd0, o_mem_req}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_req_async", {31'd0, o_mem_req}, 32'd0);
        chk("rst_ready_low", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1 i_mem_ack = 1'b1;
        @(posedge i_clk); #1 i_mem_ack = 1'b0; i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_ready_back", {31'd0, o_ready}, 32'd1);
        i_mem_ack = 1'b1;
        @(posedge i_clk); #1 i_mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("rst_no_valid", {31'd0, o_valid}, 32'd0);
            chk("rst_no_req", {31'd0, o_mem_req}, 32'd0);
        end
        @(posedge i_clk); #1;

`ifdef MEM_STAGE_TIMEOUT_EN
        begin
            exp_t e;
            e.rdata = 32'd0; e.err = 1'b1;
            sb.push_back(e);
            i_valid = 1'b1; i_addr = 32'h0000_0400; i_store = 1'b0; i_size = 2'd2;
            @(posedge i_clk); #1 i_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge i_clk);
                chk("to_req_held", {31'd0, o_mem_req}, 32'd1);
                @(posedge i_clk); #1;
            end
            @(negedge i_clk);
            chk("to_req_drop", {31'd0, o_mem_req}, 32'd0);
            chk("to_valid", {31'd0, o_valid}, 32'd1);
            @(posedge i_clk); #1;
        end
        // ack on the limit cycle completes normally
        do_req(32'h0000_0400, 32'd0, 1'b0, 2'd2, 1'b0, 32'h0BAD_F00D, 3, 0);
`else
        // without the watchdog the bus waits as long as it takes
        do_req(32'h0000_0400, 32'd0, 1'b0, 2'd2, 1'b0, 32'h0BAD_F00D, 12, 0);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
